// File: rtl/lcd_spi_pkg.sv
// Shared types and constants for the LCD SPI sequencer.
// Holds the FSM state encoding, the word/index widths and the default LCD init script.
package lcd_spi_pkg;

    localparam int unsigned WORD_W = 7;
    localparam int unsigned IDX_W  = 4;

    typedef enum logic [2:0] {
        PWRUP,
        LOAD,
        SEND,
        WAIT_DONE,
        GAP,
        IDLE
    } state_t;

    // Default LCD init script: function set, display on, clear, entry mode
    localparam logic [WORD_W-1:0] INIT_W0 = 7'h30;
    localparam logic [WORD_W-1:0] INIT_W1 = 7'h0C;
    localparam logic [WORD_W-1:0] INIT_W2 = 7'h01;
    localparam logic [WORD_W-1:0] INIT_W3 = 7'h06;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Combinational lookup of the LCD init script.
// Indices at or beyond INIT_LEN read back as 0x00.
module lcd_init_rom
    import lcd_spi_pkg::*;
#(
    parameter int unsigned INIT_LEN = 4
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [WORD_W-1:0] word_c
);

    always_comb begin
        word_c = '0;
        if (32'(idx) < INIT_LEN) begin
            case (idx)
                4'd0:    word_c = INIT_W0;
                4'd1:    word_c = INIT_W1;
                4'd2:    word_c = INIT_W2;
                4'd3:    word_c = INIT_W3;
                default: word_c = '0;
            endcase
        end
    end

endmodule

// File: rtl/lcd_spi_sequencer.sv
// Sequences spi_master: power-up delay, fixed init script, then user words via valid/ready.
// Owns spi_master's data_in/send and enforces a minimum gap after each transfer.
module lcd_spi_sequencer
    import lcd_spi_pkg::*;
#(
    parameter int unsigned POWERUP_CYCLES = 64,
    parameter int unsigned GAP_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned INIT_LEN       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              init_done,
    output logic              busy,
    output logic              err_timeout,
    output logic [WORD_W-1:0] spi_data,
    output logic              spi_send,
    input  logic              spi_done
);

    localparam int unsigned CNT_MAX = max3(POWERUP_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PWRUP_LAST   = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // A zero gap still spends one cycle in GAP
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT      = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(INIT_LEN - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [IDX_W-1:0]  idx;
    logic              done_q;
    logic              completion;
    logic [WORD_W-1:0] rom_word;

    lcd_init_rom #(
        .INIT_LEN (INIT_LEN)
    ) u_init_rom (
        .idx    (idx),
        .word_c (rom_word)
    );

    assign cnt_inc    = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
    assign completion = spi_done & ~done_q;
    assign wr_ready   = (state == IDLE);

    // Main sequencing FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PWRUP;
            cnt         <= '0;
            idx         <= '0;
            done_q      <= 1'b0;
            spi_data    <= '0;
            spi_send    <= 1'b0;
            busy        <= 1'b0;
            init_done   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            done_q   <= spi_done;
            spi_send <= 1'b0;
            case (state)
                PWRUP: begin
                    if (cnt >= PWRUP_LAST) begin
                        state <= LOAD;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                LOAD: begin
                    spi_data <= rom_word;
                    spi_send <= 1'b1;
                    busy     <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    state <= WAIT_DONE;
                    cnt   <= '0;
                end
                WAIT_DONE: begin
                    if (completion) begin
                        state <= GAP;
                        cnt   <= '0;
                    end else if (cnt >= TIMEOUT_LAST) begin
                        // Abandon the word; no retry
                        err_timeout <= 1'b1;
                        state       <= GAP;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                GAP: begin
                    if (cnt >= GAP_LAST) begin
                        cnt  <= '0;
                        busy <= 1'b0;
                        if (init_done) begin
                            state <= IDLE;
                        end else if (idx < IDX_LAST) begin
                            idx   <= idx + IDX_W'(1);
                            state <= LOAD;
                        end else begin
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                IDLE: begin
                    if (wr_valid) begin
                        spi_data <= wr_data;
                        spi_send <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                default: state <= PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_spi_sequencer.sv
// Directed bench for lcd_spi_sequencer with a simple spi_master done model.
// Expected values are hand-derived from the default parameters (64/8/256/4).
module tb_lcd_spi_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic       init_done;
    logic       busy;
    logic       err_timeout;
    logic [6:0] spi_data;
    logic       spi_send;
    logic       spi_done;

    int errors = 0;
    int checks = 0;
    int gcyc = 0;

    logic [6:0] sent_q [$];
    logic [6:0] exp_init [4] = '{7'h30, 7'h0C, 7'h01, 7'h06};

    // spi_master model: done rises 20 cycles after send and stays high 3 cycles
    int   model_mode = 0;
    int   mcnt = 0;
    int   hold = 0;
    int   rise_cyc = 0;
    logic done_m = 1'b0;
    logic done_man = 1'b0;

    logic       prev_send = 1'b0;
    logic       prev_busy = 1'b0;
    logic [6:0] prev_data = '0;

    assign spi_done = done_m | done_man;

    lcd_spi_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .init_done   (init_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .spi_data    (spi_data),
        .spi_send    (spi_send),
        .spi_done    (spi_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mcnt   = 0;
            hold   = 0;
            done_m = 1'b0;
        end else begin
            if (hold > 0) begin
                hold--;
                if (hold == 0) done_m = 1'b0;
            end
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    done_m   = 1'b1;
                    hold     = 3;
                    rise_cyc = gcyc;
                end
            end
            if (spi_send && model_mode == 0) mcnt = 20;
        end
    end

    // Log sent words; send is a single-cycle pulse and data holds while busy
    always @(negedge clk) begin
        if (rst) begin
            prev_send = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (spi_send) begin
                sent_q.push_back(spi_data);
                chk("send_one_cycle", 32'(prev_send), 32'd0);
            end
            if (busy && prev_busy) chk("data_stable", 32'(spi_data), 32'(prev_data));
            prev_send = spi_send;
            prev_busy = busy;
            prev_data = spi_data;
        end
    end

    task automatic wait_ready(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wr_ready && n < budget);
        chk(tag, 32'(wr_ready), 32'd1);
    endtask

    task automatic wait_send(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!spi_send && n < budget);
        chk(tag, 32'(spi_send), 32'd1);
    endtask

    task automatic check_init();
        chk("init_count", 32'(sent_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < sent_q.size()) chk("init_word", 32'(sent_q[i]), 32'(exp_init[i]));
        end
    endtask

    task automatic send_word(input logic [6:0] w, input string tag);
        wr_data  = w;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        chk({tag, "_send"}, 32'(spi_send), 32'd1);
        chk({tag, "_data"}, 32'(spi_data), 32'(w));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        int  s;
        int  r;
        logic bad;

        repeat (3) @(negedge clk);
        chk("rst_send", 32'(spi_send), 32'd0);
        chk("rst_data", 32'(spi_data), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);

        // Power-up delay; user word 0x41 offered from cycle 10 and held
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 10) begin
                wr_data  = 7'h41;
                wr_valid = 1'b1;
            end
        end while (!spi_send && n < 200);
        chk("first_send_cycle", 32'(n), 32'd65);
        chk("first_send_data", 32'(spi_data), 32'h30);
        chk("first_send_busy", 32'(busy), 32'd1);

        wait_ready(2000, "init_ready");
        chk("init_done", 32'(init_done), 32'd1);
        check_init();

        @(negedge clk);
        wr_valid = 1'b0;
        chk("held_send", 32'(spi_send), 32'd1);
        chk("held_data", 32'(spi_data), 32'h41);
        chk("held_ready_low", 32'(wr_ready), 32'd0);
        wait_ready(200, "held_ready");
        chk("held_count", 32'(sent_q.size()), 32'd5);
        repeat (30) @(negedge clk);
        chk("held_once", 32'(sent_q.size()), 32'd5);

        // Single user word, busy through the gap, exact gap length
        send_word(7'h31, "w31");
        chk("w31_busy", 32'(busy), 32'd1);
        bad = 1'b0;
        n = 0;
        while (!wr_ready && n < 200) begin
            if (!busy) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("w31_ready", 32'(wr_ready), 32'd1);
        chk("w31_busy_held", 32'(bad), 32'd0);
        chk("w31_idle_busy", 32'(busy), 32'd0);
        chk("w31_gap_len", 32'(gcyc - rise_cyc), 32'd9);
        chk("w31_logged", 32'(sent_q[$]), 32'h31);

        // Timeout: model never answers
        model_mode = 1;
        send_word(7'h55, "w55");
        s = gcyc;
        repeat (200) @(negedge clk);
        chk("to_err_early", 32'(err_timeout), 32'd0);
        wait_ready(400, "to_ready");
        chk("to_len", 32'(gcyc - s), 32'd265);
        chk("to_err", 32'(err_timeout), 32'd1);

        model_mode = 0;
        send_word(7'h22, "w22");
        wait_ready(200, "w22_ready");
        chk("to_err_sticky", 32'(err_timeout), 32'd1);
        chk("w22_logged", 32'(sent_q[$]), 32'h22);

        // Reset in WAIT_DONE of init word 2
        rst = 1'b1;
        @(negedge clk);
        sent_q.delete();
        rst = 1'b0;
        wait_send(200, "re_send0");
        wait_send(200, "re_send1");
        chk("re_word1", 32'(spi_data), 32'h0C);
        repeat (5) @(negedge clk);
        chk("re_in_wait", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_send", 32'(spi_send), 32'd0);
        chk("mid_rst_data", 32'(spi_data), 32'd0);
        chk("mid_rst_ready", 32'(wr_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_init_done", 32'(init_done), 32'd0);
        chk("mid_rst_err", 32'(err_timeout), 32'd0);
        sent_q.delete();
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!spi_send && n < 200);
        chk("restart_cycle", 32'(n), 32'd65);
        chk("restart_data", 32'(spi_data), 32'h30);
        wait_ready(2000, "restart_ready");
        chk("restart_init_done", 32'(init_done), 32'd1);
        check_init();

        // Done already high before send must not complete the transfer
        model_mode = 0;
        done_man   = 1'b1;
        model_mode = 1;
        repeat (3) @(negedge clk);
        send_word(7'h3A, "w3a");
        repeat (30) @(negedge clk);
        chk("dh_no_ready", 32'(wr_ready), 32'd0);
        chk("dh_busy", 32'(busy), 32'd1);
        done_man = 1'b0;
        repeat (2) @(negedge clk);
        done_man = 1'b1;
        r = gcyc;
        wait_ready(50, "dh_ready");
        chk("dh_gap_len", 32'(gcyc - r), 32'd9);
        chk("dh_err", 32'(err_timeout), 32'd0);
        done_man = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
